// File: rtl/aes_mixcolumns_iter.sv
// Handshaked AES MixColumns engine, 1/2/4 columns per BUSY cycle.
// Define INV_MIXCOLUMNS_EN to enable the inverse transform selected by the inv port.
module aes_mixcolumns_iter #(
    parameter int COLS_PER_CYCLE = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] state_in,
    input  logic         inv,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] state_out,
    output logic         busy
);

    if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_cols
        $error("COLS_PER_CYCLE must be 1, 2 or 4");
    end

    localparam logic [1:0] STEP = 2'(COLS_PER_CYCLE);

    typedef enum logic [1:0] {IDLE, BUSY, HOLD} state_t;

    function automatic logic [7:0] xt(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] mix_fwd(input logic [31:0] a);
        logic [7:0] a0, a1, a2, a3, s0, s1, s2, s3;
        a0 = a[7:0];   a1 = a[15:8];
        a2 = a[23:16]; a3 = a[31:24];
        s0 = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
        s1 = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
        s2 = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
        s3 = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
        return {s3, s2, s1, s0};
    endfunction

`ifdef INV_MIXCOLUMNS_EN
    function automatic logic [7:0] m9(input logic [7:0] x);
        return xt(xt(xt(x))) ^ x;
    endfunction

    function automatic logic [7:0] mb(input logic [7:0] x);
        return xt(xt(xt(x))) ^ xt(x) ^ x;
    endfunction

    function automatic logic [7:0] md(input logic [7:0] x);
        return xt(xt(xt(x))) ^ xt(xt(x)) ^ x;
    endfunction

    function automatic logic [7:0] me(input logic [7:0] x);
        return xt(xt(xt(x))) ^ xt(xt(x)) ^ xt(x);
    endfunction

    function automatic logic [31:0] mix_inv(input logic [31:0] a);
        logic [7:0] a0, a1, a2, a3, s0, s1, s2, s3;
        a0 = a[7:0];   a1 = a[15:8];
        a2 = a[23:16]; a3 = a[31:24];
        s0 = me(a0) ^ mb(a1) ^ md(a2) ^ m9(a3);
        s1 = m9(a0) ^ me(a1) ^ mb(a2) ^ md(a3);
        s2 = md(a0) ^ m9(a1) ^ me(a2) ^ mb(a3);
        s3 = mb(a0) ^ md(a1) ^ m9(a2) ^ me(a3);
        return {s3, s2, s1, s0};
    endfunction
`endif

    state_t       state_q, state_d;
    logic [1:0]   col_idx_q, col_idx_d;
    logic [127:0] work_q, work_d;
    logic [1:0]   col_step;

    logic [1:0]   col_sel [COLS_PER_CYCLE];
    logic [31:0]  col_old [COLS_PER_CYCLE];
    logic [31:0]  col_new [COLS_PER_CYCLE];

`ifdef INV_MIXCOLUMNS_EN
    logic mode_q, mode_d;
`else
    // Port kept for interface compatibility; the forward transform is fixed.
    logic unused_inv;
    assign unused_inv = inv;
`endif

    assign col_step = col_idx_q + STEP;

    for (genvar g = 0; g < COLS_PER_CYCLE; g++) begin : g_col
        assign col_sel[g] = col_idx_q + 2'(g);
        assign col_old[g] = work_q[{col_sel[g], 5'd0} +: 32];
`ifdef INV_MIXCOLUMNS_EN
        assign col_new[g] = mode_q ? mix_inv(col_old[g]) : mix_fwd(col_old[g]);
`else
        assign col_new[g] = mix_fwd(col_old[g]);
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            col_idx_q <= 2'd0;
            work_q    <= 128'h0;
`ifdef INV_MIXCOLUMNS_EN
            mode_q    <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            col_idx_q <= col_idx_d;
            work_q    <= work_d;
`ifdef INV_MIXCOLUMNS_EN
            mode_q    <= mode_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        col_idx_d = col_idx_q;
        work_d    = work_q;
`ifdef INV_MIXCOLUMNS_EN
        mode_d    = mode_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    state_d   = BUSY;
                    work_d    = state_in;
                    col_idx_d = 2'd0;
`ifdef INV_MIXCOLUMNS_EN
                    mode_d    = inv;
`endif
                end
            end
            BUSY: begin
                for (int k = 0; k < COLS_PER_CYCLE; k++) begin
                    work_d[{col_sel[k], 5'd0} +: 32] = col_new[k];
                end
                col_idx_d = col_step;
                // Counter wraps to zero exactly after column 3 has been updated.
                if (col_step == 2'd0) begin
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q == BUSY);
    assign out_valid = (state_q == HOLD);
    assign state_out = work_q;

endmodule

// File: doc/aes_mixcolumns_iter.md
# aes_mixcolumns_iter

Parametrised, handshaked AES MixColumns engine supporting forward and (optionally) inverse transforms, processing 1, 2 or 4 columns per clock. It sits between the ShiftRows/InvShiftRows stage and AddRoundKey in the round datapath. Its valid/ready interface replaces the single-shot ena/done pulse, so the round controller can stall the output.

## Interface
- COLS_PER_CYCLE, 1, columns transformed per BUSY cycle; legal values 1, 2, 4; any other value is an elaboration error.
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  state_in/inv valid.
- in_ready  out  1  block can accept; high only in IDLE.
- state_in  in  128  input state; byte i = state_in[8i+7:8i]; column c = bytes 4c..4c+3; row r of column c = byte 4c+r (row 0 in the LSB of the column).
- inv  in  1  0 = MixColumns, 1 = InvMixColumns; sampled only on acceptance.
- out_valid  out  1  state_out holds a completed result.
- out_ready  in  1  downstream accepts the result.
- state_out  out  128  working register, same byte order as state_in.
- busy  out  1  high in BUSY.

## Operation
- FSM states: IDLE, BUSY, HOLD.
- IDLE: in_ready=1. On in_valid=1, capture state_in into the working register and inv into the mode register; clear col_idx to 0; go to BUSY.
- BUSY: transform columns col_idx..col_idx+COLS_PER_CYCLE-1 in place; col_idx += COLS_PER_CYCLE, with a 2-bit counter that wraps to 0. After the column-3 update, go to HOLD.
- HOLD: out_valid=1 and state_out stable. On out_ready=1, go to IDLE; out_valid drops next cycle.
- Forward, column a0..a3, GF(2^8) with polynomial 0x11B:
  - s0=2a0^3a1^a2^a3
  - s1=a0^2a1^3a2^a3
  - s2=a0^a1^2a2^3a3
  - s3=3a0^a1^a2^2a3
- Inverse: rows {0e,0b,0d,09} rotated right by one per row:
  - s0=e·a0^b·a1^d·a2^9·a3
  - s1=9·a0^e·a1^b·a2^d·a3
  - Remaining rows follow the same rotation.
- Implement with xtime chains: 2x = (x<<1)^(x[7]?1B:00); 3x=2x^x; 9x=8x^x; bx=8x^2x^x; dx=8x^4x^x; ex=8x^4x^2x.
- Columns not addressed in a cycle hold their value. Column hardware is instantiated COLS_PER_CYCLE times and muxed by col_idx.
- in_valid outside IDLE: ignored; no capture; in_ready=0.
- inv changes after acceptance: no effect on the block in flight.
- state_out during BUSY: partially transformed, not valid. Only meaningful while out_valid=1.

## Timing
- Reset values: in_ready=1, out_valid=0, busy=0, state_out=128'h0, col_idx=0, FSM=IDLE.
- Reset asserted in any state discards the in-flight block immediately.
- Latency: acceptance at edge T; out_valid=1 after edge T+4/COLS_PER_CYCLE (1, 2 or 4 BUSY cycles).
- Throughput with out_ready tied high: one block per 4/COLS_PER_CYCLE+2 cycles (IDLE + BUSY cycles + HOLD).
- Back-to-back: no acceptance in the cycle out_valid&out_ready fires. in_ready rises the following cycle.
- out_ready low in HOLD: stall indefinitely, state_out unchanged.

## Configuration
- INV_MIXCOLUMNS_EN defined: the inv port selects the inverse transform; inverse multipliers are synthesised.
- INV_MIXCOLUMNS_EN undefined: the inv port is present but ignored; the forward transform is always used; no inverse logic is synthesised. The mode register is removed.

## Test plan
- FIPS-197 columns, forward, COLS_PER_CYCLE=1, out_ready=1. Input columns (row0..row3) db135345, f20a225c, 01010101, c6c6c6c6 → output columns 8e4da1bc, 9fdc589d, 01010101, c6c6c6c6. out_valid rises 4 cycles after acceptance.
- Same input with COLS_PER_CYCLE=2 and COLS_PER_CYCLE=4 → identical result; latency 2 and 1 cycles respectively.
- INV_MIXCOLUMNS_EN defined, inv=1. Feed the forward result above → original state returned. Column d4d4d4d5 forward → d5d5d7d6; inverse of d5d5d7d6 → d4d4d4d5.
- out_ready held low for 10 cycles in HOLD → out_valid stays 1, state_out constant, in_ready=0. Raising out_ready gives one handshake, and in_ready=1 the next cycle.
- rst pulsed while in BUSY at col_idx=2 → out_valid=0, state_out=0, in_ready=1 immediately. The next accepted block produces a correct result with no residue.
- Without INV_MIXCOLUMNS_EN, inv=1 with column 2d26314c → 4d7ebdf8 (forward result).
